// File: rtl/rob_commit_if.sv
// Commit-side bundle between the ROB head, the commit controller and the
// rename/free-list/fetch consumers. master = ROB side, slave = commit controller.
interface rob_commit_if #(
    parameter int PREG_W = 6
);
    logic              head_good0, head_good1;
    logic [31:0]       uop0_pc, uop1_pc;
    logic              uop0_is_br, uop1_is_br;
    logic              uop0_pred_taken, uop1_pred_taken;
    logic [31:0]       uop0_pred_addr, uop1_pred_addr;
    logic              uop0_br_taken, uop1_br_taken;
    logic [31:0]       uop0_br_addr, uop1_br_addr;
    logic              uop0_wb_en, uop1_wb_en;
    logic [4:0]        uop0_arch_dst, uop1_arch_dst;
    logic [PREG_W-1:0] uop0_phys_dst, uop1_phys_dst;
    logic [PREG_W-1:0] uop0_old_phys, uop1_old_phys;
    logic              commit_stall;

    logic              rob_ack0, rob_ack1;
    logic              cm_valid0, cm_valid1;
    logic [4:0]        cm_arch_dst0, cm_arch_dst1;
    logic [PREG_W-1:0] cm_phys_dst0, cm_phys_dst1;
    logic [PREG_W-1:0] cm_free0, cm_free1;
    logic              flush_req;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic [31:0]       retired_cnt;
    logic [1:0]        dbg_state;

    // Handshake: rob_ack0/1 are same-cycle retire strobes with no backpressure
    // from the ROB; the ROB must mark the slot committed on the clock edge
    // where the ack is high. cm_* are one-cycle-later valid-only strobes.
    modport master (
        output head_good0, head_good1, uop0_pc, uop1_pc, uop0_is_br, uop1_is_br,
               uop0_pred_taken, uop1_pred_taken, uop0_pred_addr, uop1_pred_addr,
               uop0_br_taken, uop1_br_taken, uop0_br_addr, uop1_br_addr,
               uop0_wb_en, uop1_wb_en, uop0_arch_dst, uop1_arch_dst,
               uop0_phys_dst, uop1_phys_dst, uop0_old_phys, uop1_old_phys, commit_stall,
        input  rob_ack0, rob_ack1, cm_valid0, cm_valid1, cm_arch_dst0, cm_arch_dst1,
               cm_phys_dst0, cm_phys_dst1, cm_free0, cm_free1, flush_req,
               redirect_valid, redirect_pc, retired_cnt, dbg_state
    );

    modport slave (
        input  head_good0, head_good1, uop0_pc, uop1_pc, uop0_is_br, uop1_is_br,
               uop0_pred_taken, uop1_pred_taken, uop0_pred_addr, uop1_pred_addr,
               uop0_br_taken, uop1_br_taken, uop0_br_addr, uop1_br_addr,
               uop0_wb_en, uop1_wb_en, uop0_arch_dst, uop1_arch_dst,
               uop0_phys_dst, uop1_phys_dst, uop0_old_phys, uop1_old_phys, commit_stall,
        output rob_ack0, rob_ack1, cm_valid0, cm_valid1, cm_arch_dst0, cm_arch_dst1,
               cm_phys_dst0, cm_phys_dst1, cm_free0, cm_free1, flush_req,
               redirect_valid, redirect_pc, retired_cnt, dbg_state
    );
endinterface

// File: rtl/rob_commit_ctrl.sv
// Two-wide ROB commit controller: picks retiring head slots, forwards rename
// updates, and sequences mispredict flushes after the MIPS delay slot retires.
module rob_commit_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int PREG_W       = 6
) (
    input logic        clk,
    input logic        rst,
    rob_commit_if.slave bus
);
    typedef enum logic [1:0] {RUN = 2'd0, WAIT_DS = 2'd1, FLUSH = 2'd2} state_t;

    localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(FLUSH_CYCLES - 1);

    state_t      state, state_n;
    logic        ds_slot1, ds_slot1_n;
    logic [31:0] target, target_n;
    logic [CW-1:0] cnt, cnt_n;
    logic        ack0, ack1;
    logic        mis0, mis1;
    logic [31:0] tgt0, tgt1;

    logic              cm_valid0_q, cm_valid1_q;
    logic [4:0]        cm_arch0_q, cm_arch1_q;
    logic [PREG_W-1:0] cm_phys0_q, cm_phys1_q, cm_free0_q, cm_free1_q;
    logic [31:0]       retired_q;

    function automatic logic mispredict(input logic is_br, input logic pt, input logic [31:0] pa,
                                        input logic bt, input logic [31:0] ba);
        return is_br && ((bt != pt) || (bt && (ba != pa)));
    endfunction

    assign mis0 = mispredict(bus.uop0_is_br, bus.uop0_pred_taken, bus.uop0_pred_addr,
                             bus.uop0_br_taken, bus.uop0_br_addr);
    assign mis1 = mispredict(bus.uop1_is_br, bus.uop1_pred_taken, bus.uop1_pred_addr,
                             bus.uop1_br_taken, bus.uop1_br_addr);
    assign tgt0 = bus.uop0_br_taken ? bus.uop0_br_addr : bus.uop0_pc + 32'd8;
    assign tgt1 = bus.uop1_br_taken ? bus.uop1_br_addr : bus.uop1_pc + 32'd8;

    always_comb begin
        state_n    = state;
        ds_slot1_n = ds_slot1;
        target_n   = target;
        cnt_n      = cnt;
        ack0       = 1'b0;
        ack1       = 1'b0;
        unique case (state)
            RUN: begin
                if (!bus.commit_stall) begin
                    ack0 = bus.head_good0;
                    // head_good0 cannot tell "absent" from "unfinished", so slot1
                    // only retires together with slot0 to keep commit in order.
                    ack1 = bus.head_good1 && ack0;
                    if (ack0 && mis0) begin
                        target_n   = tgt0;
                        ds_slot1_n = 1'b0;
                        state_n    = ack1 ? FLUSH : WAIT_DS;
                    end else if (ack1 && mis1) begin
                        target_n   = tgt1;
                        ds_slot1_n = 1'b1;
                        state_n    = WAIT_DS;
                    end
                end
            end
            WAIT_DS: begin
                if (!bus.commit_stall) begin
                    if (ds_slot1) ack0 = bus.head_good0;
                    else          ack1 = bus.head_good1;
                    if (ack0 || ack1) state_n = FLUSH;
                end
            end
            FLUSH: begin
                if (cnt == LAST) begin
                    state_n = RUN;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = RUN;
        endcase
        if (!rst) begin
            ack0 = 1'b0;
            ack1 = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= RUN;
            ds_slot1    <= 1'b0;
            target      <= '0;
            cnt         <= '0;
            cm_valid0_q <= 1'b0;
            cm_valid1_q <= 1'b0;
            cm_arch0_q  <= '0;
            cm_arch1_q  <= '0;
            cm_phys0_q  <= '0;
            cm_phys1_q  <= '0;
            cm_free0_q  <= '0;
            cm_free1_q  <= '0;
            retired_q   <= '0;
        end else begin
            state       <= state_n;
            ds_slot1    <= ds_slot1_n;
            target      <= target_n;
            cnt         <= cnt_n;
            cm_valid0_q <= ack0 && bus.uop0_wb_en;
            cm_valid1_q <= ack1 && bus.uop1_wb_en;
            cm_arch0_q  <= bus.uop0_arch_dst;
            cm_arch1_q  <= bus.uop1_arch_dst;
            cm_phys0_q  <= bus.uop0_phys_dst;
            cm_phys1_q  <= bus.uop1_phys_dst;
            cm_free0_q  <= bus.uop0_old_phys;
            cm_free1_q  <= bus.uop1_old_phys;
            retired_q   <= retired_q + 32'(ack0) + 32'(ack1);
        end
    end

    assign bus.rob_ack0       = ack0;
    assign bus.rob_ack1       = ack1;
    assign bus.cm_valid0      = cm_valid0_q;
    assign bus.cm_valid1      = cm_valid1_q;
    assign bus.cm_arch_dst0   = cm_arch0_q;
    assign bus.cm_arch_dst1   = cm_arch1_q;
    assign bus.cm_phys_dst0   = cm_phys0_q;
    assign bus.cm_phys_dst1   = cm_phys1_q;
    assign bus.cm_free0       = cm_free0_q;
    assign bus.cm_free1       = cm_free1_q;
    assign bus.flush_req      = (state == FLUSH);
    assign bus.redirect_valid = (state == FLUSH) && (cnt == '0);
    assign bus.redirect_pc    = target;
    assign bus.retired_cnt    = retired_q;
    assign bus.dbg_state      = state;
endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Self-checking bench for rob_commit_ctrl: per-scenario tasks plus a commit
// scoreboard matching registered rename/free-list strobes.
module tb_rob_commit_ctrl;
  localparam int PREG_W = 6;
  localparam int W = 5 + 2 * PREG_W;
  localparam logic [1:0] S_RUN = 2'd0, S_WAIT = 2'd1, S_FLUSH = 2'd2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int compared = 0;
  int failed = 0;
  logic [31:0] exp_retired = 0;
  logic [W-1:0] exp_q[$];
  logic [1:0] obs;

  rob_commit_if #(.PREG_W(PREG_W)) bus ();
  rob_commit_ctrl #(.FLUSH_CYCLES(2), .PREG_W(PREG_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard: every registered commit strobe must match the next expected entry
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (bus.cm_valid0 === 1'b1) begin
      compared++;
      if (exp_q.size() == 0) begin
        failed++; $display("FAIL cm0_unexpected got=%h required=none", {bus.cm_arch_dst0, bus.cm_phys_dst0, bus.cm_free0});
      end else begin
        e = exp_q.pop_front();
        if ({bus.cm_arch_dst0, bus.cm_phys_dst0, bus.cm_free0} !== e) begin
          failed++; $display("FAIL cm0_data got=%h required=%h", {bus.cm_arch_dst0, bus.cm_phys_dst0, bus.cm_free0}, e);
        end
      end
    end
    if (bus.cm_valid1 === 1'b1) begin
      compared++;
      if (exp_q.size() == 0) begin
        failed++; $display("FAIL cm1_unexpected got=%h required=none", {bus.cm_arch_dst1, bus.cm_phys_dst1, bus.cm_free1});
      end else begin
        e = exp_q.pop_front();
        if ({bus.cm_arch_dst1, bus.cm_phys_dst1, bus.cm_free1} !== e) begin
          failed++; $display("FAIL cm1_data got=%h required=%h", {bus.cm_arch_dst1, bus.cm_phys_dst1, bus.cm_free1}, e);
        end
      end
    end
  end

  // driver tasks
  task automatic rand_fields();
    bus.uop0_pc = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
    bus.uop1_pc = bus.uop0_pc + 32'd4;
    {bus.uop0_is_br, bus.uop0_pred_taken, bus.uop0_br_taken} = 3'b000;
    {bus.uop1_is_br, bus.uop1_pred_taken, bus.uop1_br_taken} = 3'b000;
    bus.uop0_pred_addr = '0; bus.uop0_br_addr = '0;
    bus.uop1_pred_addr = '0; bus.uop1_br_addr = '0;
    bus.uop0_wb_en = 1'($urandom_range(0, 1));
    bus.uop1_wb_en = 1'($urandom_range(0, 1));
    bus.uop0_arch_dst = 5'($urandom_range(0, 31));
    bus.uop1_arch_dst = 5'($urandom_range(0, 31));
    bus.uop0_phys_dst = PREG_W'($urandom_range(0, 63));
    bus.uop1_phys_dst = PREG_W'($urandom_range(0, 63));
    bus.uop0_old_phys = PREG_W'($urandom_range(0, 63));
    bus.uop1_old_phys = PREG_W'($urandom_range(0, 63));
  endtask

  // Called at a negedge: applies one row, records the expected commits, returns
  // the observed acks, and advances to the next negedge.
  task automatic drive(input logic g0, input logic g1, input logic st, input logic [1:0] e,
                       output logic [1:0] o);
    bus.head_good0 = g0; bus.head_good1 = g1; bus.commit_stall = st;
    #1;
    o = {bus.rob_ack0, bus.rob_ack1};
    if (e[1] && bus.uop0_wb_en) exp_q.push_back({bus.uop0_arch_dst, bus.uop0_phys_dst, bus.uop0_old_phys});
    if (e[0] && bus.uop1_wb_en) exp_q.push_back({bus.uop1_arch_dst, bus.uop1_phys_dst, bus.uop1_old_phys});
    exp_retired = exp_retired + 32'(e[1]) + 32'(e[0]);
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    rand_fields();
    bus.head_good0 = 1'b1; bus.head_good1 = 1'b1; bus.commit_stall = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    compared++; if (bus.dbg_state !== S_RUN) begin failed++; $display("FAIL rst_state got=%0d required=%0d", bus.dbg_state, S_RUN); end
    compared++; if ({bus.rob_ack0, bus.rob_ack1} !== 2'b00) begin failed++; $display("FAIL rst_acks got=%b required=00", {bus.rob_ack0, bus.rob_ack1}); end
    compared++; if ({bus.flush_req, bus.redirect_valid, bus.cm_valid0, bus.cm_valid1} !== 4'b0000) begin failed++; $display("FAIL rst_strobes got=%b required=0000", {bus.flush_req, bus.redirect_valid, bus.cm_valid0, bus.cm_valid1}); end
    compared++; if ({bus.retired_cnt, bus.redirect_pc} !== 64'd0) begin failed++; $display("FAIL rst_regs got=%h/%h required=0/0", bus.retired_cnt, bus.redirect_pc); end
    bus.head_good0 = 1'b0; bus.head_good1 = 1'b0;
    rst = 1'b1;
    exp_retired = 0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      rand_fields();
      drive(1, 1, 0, 2'b11, obs);
      compared++; if (obs !== 2'b11) begin failed++; $display("FAIL b2b_ack%0d got=%b required=11", i, obs); end
    end
    compared++; if (bus.retired_cnt !== 32'd6) begin failed++; $display("FAIL b2b_retired got=%0d required=6", bus.retired_cnt); end
    drive(0, 0, 0, 2'b00, obs);
    compared++; if (exp_q.size() != 0) begin failed++; $display("FAIL b2b_cm_pending got=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_order();
    rand_fields();
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 0, 2'b00, obs);
      compared++; if (obs !== 2'b00) begin failed++; $display("FAIL order_hold%0d got=%b required=00", i, obs); end
    end
    drive(1, 1, 0, 2'b11, obs);
    compared++; if (obs !== 2'b11) begin failed++; $display("FAIL order_release got=%b required=11", obs); end
  endtask

  task automatic test_stall();
    rand_fields();
    drive(1, 0, 1, 2'b00, obs);
    compared++; if (obs !== 2'b00) begin failed++; $display("FAIL stall_block got=%b required=00", obs); end
    drive(1, 0, 0, 2'b10, obs);
    compared++; if (obs !== 2'b10) begin failed++; $display("FAIL stall_release got=%b required=10", obs); end
  endtask

  task automatic test_correct_branch();
    rand_fields();
    bus.uop0_is_br = 1; bus.uop0_pred_taken = 1; bus.uop0_pred_addr = 32'h6000;
    bus.uop0_br_taken = 1; bus.uop0_br_addr = 32'h6000;
    drive(1, 1, 0, 2'b11, obs);
    compared++; if (obs !== 2'b11) begin failed++; $display("FAIL okbr_ack got=%b required=11", obs); end
    compared++; if ({bus.dbg_state, bus.flush_req} !== {S_RUN, 1'b0}) begin failed++; $display("FAIL okbr_state got=%0d/%b required=0/0", bus.dbg_state, bus.flush_req); end
  endtask

  // Three cycles after the row that completes the delay slot: redirect+flush,
  // flush only, then back in RUN.
  task automatic flush_sequence(input string tag, input logic [31:0] exp_pc);
    compared++; if ({bus.redirect_valid, bus.flush_req, bus.dbg_state} !== {2'b11, S_FLUSH}) begin failed++; $display("FAIL %s_flush0 got=%b%b/%0d required=11/2", tag, bus.redirect_valid, bus.flush_req, bus.dbg_state); end
    compared++; if (bus.redirect_pc !== exp_pc) begin failed++; $display("FAIL %s_redirect_pc got=%h required=%h", tag, bus.redirect_pc, exp_pc); end
    drive(1, 1, 0, 2'b00, obs);
    compared++; if (obs !== 2'b00) begin failed++; $display("FAIL %s_flush_ack0 got=%b required=00", tag, obs); end
    compared++; if ({bus.redirect_valid, bus.flush_req} !== 2'b01) begin failed++; $display("FAIL %s_flush1 got=%b%b required=01", tag, bus.redirect_valid, bus.flush_req); end
    drive(1, 1, 0, 2'b00, obs);
    compared++; if (obs !== 2'b00) begin failed++; $display("FAIL %s_flush_ack1 got=%b required=00", tag, obs); end
    compared++; if ({bus.flush_req, bus.dbg_state} !== {1'b0, S_RUN}) begin failed++; $display("FAIL %s_resume got=%b/%0d required=0/0", tag, bus.flush_req, bus.dbg_state); end
    drive(0, 0, 0, 2'b00, obs);
  endtask

  task automatic test_mispredict_slot0_row();
    rand_fields();
    bus.uop0_pc = 32'h1000; bus.uop1_pc = 32'h1004;
    bus.uop0_is_br = 1; bus.uop0_pred_taken = 0; bus.uop0_br_taken = 1; bus.uop0_br_addr = 32'h2000;
    drive(1, 1, 0, 2'b11, obs);
    compared++; if (obs !== 2'b11) begin failed++; $display("FAIL m0_ack got=%b required=11", obs); end
    bus.uop0_is_br = 0;
    flush_sequence("m0", 32'h2000);
  endtask

  task automatic test_mispredict_slot0_split();
    rand_fields();
    bus.uop0_pc = 32'h7000;
    bus.uop0_is_br = 1; bus.uop0_pred_taken = 1; bus.uop0_pred_addr = 32'h4000;
    bus.uop0_br_taken = 1; bus.uop0_br_addr = 32'h5000;
    drive(1, 0, 0, 2'b10, obs);
    compared++; if (obs !== 2'b10) begin failed++; $display("FAIL m0s_ack got=%b required=10", obs); end
    compared++; if ({bus.dbg_state, bus.flush_req} !== {S_WAIT, 1'b0}) begin failed++; $display("FAIL m0s_wait got=%0d/%b required=1/0", bus.dbg_state, bus.flush_req); end
    rand_fields();
    drive(1, 1, 1, 2'b00, obs);
    compared++; if (obs !== 2'b00) begin failed++; $display("FAIL m0s_stall got=%b required=00", obs); end
    drive(1, 1, 0, 2'b01, obs);
    compared++; if (obs !== 2'b01) begin failed++; $display("FAIL m0s_ds_ack got=%b required=01", obs); end
    flush_sequence("m0s", 32'h5000);
  endtask

  task automatic test_mispredict_slot1();
    rand_fields();
    bus.uop0_pc = 32'h1000; bus.uop1_pc = 32'h1004;
    bus.uop1_is_br = 1; bus.uop1_pred_taken = 1; bus.uop1_pred_addr = 32'h3000; bus.uop1_br_taken = 0;
    drive(1, 1, 0, 2'b11, obs);
    compared++; if (obs !== 2'b11) begin failed++; $display("FAIL m1_ack got=%b required=11", obs); end
    compared++; if ({bus.dbg_state, bus.flush_req} !== {S_WAIT, 1'b0}) begin failed++; $display("FAIL m1_wait got=%0d/%b required=1/0", bus.dbg_state, bus.flush_req); end
    rand_fields();
    drive(1, 1, 0, 2'b10, obs);
    compared++; if (obs !== 2'b10) begin failed++; $display("FAIL m1_ds_ack got=%b required=10", obs); end
    flush_sequence("m1", 32'h100C);
  endtask

  task automatic test_reset_mid_flush();
    rand_fields();
    bus.uop0_pc = 32'h1000;
    bus.uop0_is_br = 1; bus.uop0_pred_taken = 0; bus.uop0_br_taken = 1; bus.uop0_br_addr = 32'h2000;
    drive(1, 1, 0, 2'b11, obs);
    bus.uop0_is_br = 0;
    drive(0, 0, 0, 2'b00, obs);
    compared++; if ({bus.flush_req, bus.redirect_valid} !== 2'b10) begin failed++; $display("FAIL rstf_second got=%b%b required=10", bus.flush_req, bus.redirect_valid); end
    rst = 1'b0;
    drive(0, 0, 0, 2'b00, obs);
    rst = 1'b1;
    exp_retired = 0;
    compared++; if ({bus.flush_req, bus.dbg_state} !== {1'b0, S_RUN}) begin failed++; $display("FAIL rstf_state got=%b/%0d required=0/0", bus.flush_req, bus.dbg_state); end
    compared++; if (bus.retired_cnt !== 32'd0) begin failed++; $display("FAIL rstf_retired got=%0d required=0", bus.retired_cnt); end
  endtask

  initial begin
    bus.head_good0 = 0; bus.head_good1 = 0; bus.commit_stall = 0;
    rand_fields();
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_order();
    test_stall();
    test_correct_branch();
    compared++; if (bus.retired_cnt !== exp_retired) begin failed++; $display("FAIL retired_mid got=%0d required=%0d", bus.retired_cnt, exp_retired); end
    test_mispredict_slot0_row();
    test_mispredict_slot0_split();
    test_mispredict_slot1();
    compared++; if (bus.retired_cnt !== exp_retired) begin failed++; $display("FAIL retired_end got=%0d required=%0d", bus.retired_cnt, exp_retired); end
    test_reset_mid_flush();
    drive(0, 0, 0, 2'b00, obs);
    compared++; if (exp_q.size() != 0) begin failed++; $display("FAIL cm_pending got=%0d required=0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end
endmodule

// File: doc/rob_commit_ctrl.md
Name: rob_commit_ctrl

Overview:
- Sits between the ROB head and the rename map, free list and fetch redirect.
- Each cycle it decides which of the two head slots retire, and forwards their architectural updates to rename and the free list.
- It detects branch mispredicts at commit and retires the MIPS delay slot before requesting a pipeline flush.
- It sequences the flush: it holds the flush for a fixed number of cycles, then resumes commit.

Parameters:
- FLUSH_CYCLES, 2, cycles `flush_req` is held high per mispredict (≥1).
- PREG_W, 6, physical register index width.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous reset, active-low.
- `head_good0`, `head_good1`  in  1 each  slot0/slot1 at ROB head is valid, not committed and finished.
- `uopN_pc`  in  32  PC of slot N (N=0,1).
- `uopN_is_br`  in  1  slot N is a branch or jump.
- `uopN_pred_taken`  in  1  fetch prediction.
- `uopN_pred_addr`  in  32  predicted target.
- `uopN_br_taken`  in  1  resolved direction.
- `uopN_br_addr`  in  32  resolved target.
- `uopN_wb_en`  in  1  writes an architectural register.
- `uopN_arch_dst`  in  5  architectural destination.
- `uopN_phys_dst`  in  PREG_W  new physical register.
- `uopN_old_phys`  in  PREG_W  previous mapping, to be freed.
- `commit_stall`  in  1  downstream (store buffer) cannot accept retirement this cycle.
- `rob_ack0`, `rob_ack1`  out  1 each  slot retires this cycle; the ROB marks it committed.
- `cm_valid0/1`  out  1 each  registered commit strobe to rename/free list.
- `cm_arch_dst0/1`  out  5  registered.
- `cm_phys_dst0/1`  out  PREG_W  registered.
- `cm_free0/1`  out  PREG_W  registered.
- `flush_req`  out  1  pipeline flush.
- `redirect_valid`  out  1  one-cycle fetch redirect.
- `redirect_pc`  out  32  redirect target.
- `retired_cnt`  out  32  instructions retired.

Behaviour:
- States: RUN, WAIT_DS, FLUSH. Reset (`rst`=0 at a clock edge) gives the following:
  - state=RUN.
  - All outputs 0.
  - Flush counter 0 and the saved target 0.
  - Reset overrides everything, including mid-FLUSH.
- Mispredict for slot N: `is_br` && (`br_taken`≠`pred_taken` || (`br_taken` && `br_addr`≠`pred_addr`)).
- Target: `br_taken` ? `br_addr` : `pc`+8, mod 2^32.
- RUN, `commit_stall`=1: both acks 0.
- RUN, no stall:
  - `ack0` = `head_good0`.
  - `ack1` = `head_good1` && (`ack0` || !`head_good0`-because-absent). Slot1 never retires ahead of a present but unfinished slot0, so `ack1` requires slot0 retired this cycle or slot0 absent.
  - Slot0 mispredicts and `ack1` (delay slot in same row): save the target, go to FLUSH.
  - Slot0 mispredicts and !`ack1`: save the target, go to WAIT_DS; only slot1 of that row may retire next. Once it does, go to FLUSH.
  - Slot1 mispredicts and is acked: save the target, go to WAIT_DS. The delay slot is slot0 of the next row.
- WAIT_DS (slot0 branch case):
  - `ack1` only; `ack0`=0.
  - Acked: go to FLUSH.
- WAIT_DS (slot1 branch case):
  - `ack0` only; `ack1`=0.
  - Acked: go to FLUSH.
- WAIT_DS: track which case applies with a 1-bit flag. `commit_stall` still blocks the ack.
- FLUSH:
  - Entry cycle: `redirect_valid`=1 for exactly one cycle with `redirect_pc` = saved target.
  - `flush_req`=1 for FLUSH_CYCLES cycles; acks 0.
  - Return to RUN after the count expires.
- Acks are combinational from state and inputs, the same cycle.
- `cm_*` outputs are registered: 1 cycle after the ack, with `cm_valid` = ack && `wb_en`. Non-writing uops are counted but not forwarded.
- `retired_cnt` += popcount(`ack0`,`ack1`) each cycle; wraps at 2^32.
- A correctly predicted branch causes no state change.

Test Plan:
- Both slots good, no branches, 3 rows back-to-back -> `ack0`=`ack1`=1 each cycle; `retired_cnt`=6; `cm_valid` one cycle after each ack.
- `head_good0`=0, `head_good1`=1 -> `ack1`=0 until slot0 good.
- `head_good0`=1, `commit_stall`=1 -> acks 0; release -> ack next cycle.
- Slot0 branch at `pc`=0x1000, pred not-taken, resolved taken to 0x2000, slot1 good -> both ack; next cycle `redirect_valid`=1, `redirect_pc`=0x2000; `flush_req` high 2 cycles; then RUN.
- Slot1 branch at `pc`=0x1004, pred taken to 0x3000, resolved not-taken -> WAIT_DS; next row slot0 acked, slot1 not; `redirect_pc`=0x100C; `flush_req` 2 cycles.
- `rst` low during the 2nd FLUSH cycle -> next cycle `flush_req`=0, state RUN, `retired_cnt`=0.
